// File: rtl/menu_pkg.sv
// -----------------------------------------------------------------------------
// menu_pkg
// Shared types and constants for the on-screen settings menu controller.
//   - menu_state_e : controller state encoding
//   - FLAG_*       : bit positions of the enable flags in the flag vector
//   - MENU_ROW_*   : highlight-bar geometry (top row and row pitch in pixels)
//   - row_y()      : row index -> top coordinate of that row
// Optional feature macro: MENU_TIMEOUT_EN (adds the TIMED_OUT state).
// -----------------------------------------------------------------------------
package menu_pkg;

    localparam int DEFAULT_NUM_ITEMS = 5;
    localparam int NUM_FLAGS         = 5;

    localparam int FLAG_AXIS = 0;
    localparam int FLAG_GRID = 1;
    localparam int FLAG_TICK = 2;
    localparam int FLAG_WAVE = 3;
    localparam int FLAG_IMBA = 4;

    localparam int MENU_ROW_BASE  = 688;
    localparam int MENU_ROW_PITCH = 24;

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'd0,
        ST_NAV     = 2'd1,
        ST_LOCKOUT = 2'd2
`ifdef MENU_TIMEOUT_EN
        ,
        ST_TIMED_OUT = 2'd3
`endif
    } menu_state_e;

    // The constant x24 pitch reduces to (row<<4) + (row<<3): no multiplier.
    function automatic logic [11:0] row_y(input logic [2:0] row);
        return 12'(MENU_ROW_BASE + int'(row) * MENU_ROW_PITCH);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// -----------------------------------------------------------------------------
// btn_edge
// Rising-edge detector for one debounced button level.
//   clk   in  1  clock
//   rst   in  1  synchronous, active-high reset
//   btn   in  1  debounced button level
//   press out 1  one-cycle pulse in the cycle the level is first sampled high
// A button already held while reset is asserted does not produce a press:
// the detector stays disarmed for the first cycle after reset so that the
// previous-sample register has captured the real level before edges count.
// -----------------------------------------------------------------------------
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic prev;
    logic armed;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev  <= btn;
            armed <= 1'b1;
        end
    end

    assign press = armed & btn & ~prev;

endmodule

// File: rtl/menu_ctrl.sv
// -----------------------------------------------------------------------------
// menu_ctrl
// Settings-menu sequencer: turns three debounced button levels into cursor
// moves and flag toggles, owns the renderer enable flags and produces the
// highlight-bar row coordinate.
//   CLOCK, RESET                 clock and synchronous active-high reset
//   Menu_Sw                      menu enable switch (level)
//   BTN_UP, BTN_DOWN, BTN_SEL    debounced button levels
//   Axis_On .. Imba_On           registered enable flags
//   Menu_Active                  menu visible (NAV or LOCKOUT)
//   Cursor [2:0]                 selected row
//   Cursor_Y [11:0]              row top = 688 + 24*Cursor, one cycle behind Cursor
// Optional feature macro: MENU_TIMEOUT_EN -- idle auto-close after
// TIMEOUT_CYCLES cycles in NAV without an accepted press.
// -----------------------------------------------------------------------------
module menu_ctrl
    import menu_pkg::*;
#(
    parameter int unsigned          NUM_ITEMS     = DEFAULT_NUM_ITEMS,
    parameter logic [NUM_FLAGS-1:0] DEFAULT_FLAGS = 5'b01111,
    parameter int unsigned          LOCK_CYCLES   = 16
`ifdef MENU_TIMEOUT_EN
    ,
    parameter logic [23:0]          TIMEOUT_CYCLES = 24'd10_000_000
`endif
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        Menu_Sw,
    input  logic        BTN_UP,
    input  logic        BTN_DOWN,
    input  logic        BTN_SEL,
    output logic        Axis_On,
    output logic        Grid_On,
    output logic        Tick_On,
    output logic        Wave_On,
    output logic        Imba_On,
    output logic        Menu_Active,
    output logic [2:0]  Cursor,
    output logic [11:0] Cursor_Y
);

    localparam int          LOCK_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [2:0]  LAST_ROW  = 3'(NUM_ITEMS - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

    logic up_p, down_p, sel_p;

    btn_edge u_edge_up   (.clk(CLOCK), .rst(RESET), .btn(BTN_UP),   .press(up_p));
    btn_edge u_edge_down (.clk(CLOCK), .rst(RESET), .btn(BTN_DOWN), .press(down_p));
    btn_edge u_edge_sel  (.clk(CLOCK), .rst(RESET), .btn(BTN_SEL),  .press(sel_p));

    menu_state_e          state;
    logic [NUM_FLAGS-1:0] flags;
    logic [2:0]           cursor;
    logic [11:0]          cursor_y;
    logic                 menu_active;
    logic [LOCK_W-1:0]    lock_cnt;
    logic [NUM_FLAGS-1:0] sel_mask;
`ifdef MENU_TIMEOUT_EN
    logic [23:0]          idle_cnt;
`endif

    assign sel_mask = {{(NUM_FLAGS-1){1'b0}}, 1'b1} << cursor;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state       <= ST_CLOSED;
            flags       <= DEFAULT_FLAGS;
            cursor      <= '0;
            cursor_y    <= row_y(3'd0);
            menu_active <= 1'b0;
            lock_cnt    <= '0;
`ifdef MENU_TIMEOUT_EN
            idle_cnt    <= '0;
`endif
        end else begin
            cursor_y <= row_y(cursor);
            // Dropping the switch closes the menu from any state; flags persist.
            if (!Menu_Sw) begin
                state       <= ST_CLOSED;
                cursor      <= '0;
                menu_active <= 1'b0;
            end else begin
                case (state)
                    ST_CLOSED: begin
                        state       <= ST_NAV;
                        cursor      <= '0;
                        menu_active <= 1'b1;
`ifdef MENU_TIMEOUT_EN
                        idle_cnt    <= '0;
`endif
                    end
                    ST_NAV: begin
                        // SEL wins over UP/DOWN; UP with DOWN cancels out.
                        if (sel_p) begin
                            flags    <= flags ^ sel_mask;
                            state    <= ST_LOCKOUT;
                            lock_cnt <= '0;
`ifdef MENU_TIMEOUT_EN
                            idle_cnt <= '0;
`endif
                        end else if (up_p && !down_p) begin
                            cursor   <= (cursor == 3'd0) ? LAST_ROW : cursor - 3'd1;
`ifdef MENU_TIMEOUT_EN
                            idle_cnt <= '0;
`endif
                        end else if (down_p && !up_p) begin
                            cursor   <= (cursor == LAST_ROW) ? 3'd0 : cursor + 3'd1;
`ifdef MENU_TIMEOUT_EN
                            idle_cnt <= '0;
`endif
                        end
`ifdef MENU_TIMEOUT_EN
                        else if (idle_cnt == TIMEOUT_CYCLES - 24'd1) begin
                            state       <= ST_TIMED_OUT;
                            cursor      <= '0;
                            menu_active <= 1'b0;
                        end else begin
                            idle_cnt <= idle_cnt + 24'd1;
                        end
`endif
                    end
                    ST_LOCKOUT: begin
                        // Exactly LOCK_CYCLES cycles in this state, presses ignored.
                        if (lock_cnt == LOCK_LAST) begin
                            state <= ST_NAV;
                        end else begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end
                    end
`ifdef MENU_TIMEOUT_EN
                    ST_TIMED_OUT: begin
                        state <= ST_TIMED_OUT;
                    end
`endif
                    default: begin
                        state       <= ST_CLOSED;
                        cursor      <= '0;
                        menu_active <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Axis_On     = flags[FLAG_AXIS];
    assign Grid_On     = flags[FLAG_GRID];
    assign Tick_On     = flags[FLAG_TICK];
    assign Wave_On     = flags[FLAG_WAVE];
    assign Imba_On     = flags[FLAG_IMBA];
    assign Menu_Active = menu_active;
    assign Cursor      = cursor;
    assign Cursor_Y    = cursor_y;

endmodule

// File: tb/tb_menu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_menu_ctrl
// Directed bench for menu_ctrl: a cycle-by-cycle vector table for navigation,
// wrap-around and simultaneous presses, followed by hand-written sequences for
// lockout timing, closing mid-lockout, reset mid-lockout and (with
// MENU_TIMEOUT_EN) the idle auto-close.
// Inputs change 1 ns after a rising edge; outputs are checked at that point,
// i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_menu_ctrl;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        Menu_Sw;
    logic        BTN_UP, BTN_DOWN, BTN_SEL;
    logic        Axis_On, Grid_On, Tick_On, Wave_On, Imba_On;
    logic        Menu_Active;
    logic [2:0]  Cursor;
    logic [11:0] Cursor_Y;
    logic [4:0]  flags_o;

    assign flags_o = {Imba_On, Wave_On, Tick_On, Grid_On, Axis_On};

    always #5 CLOCK = ~CLOCK;

    menu_ctrl #(
        .NUM_ITEMS    (5),
        .DEFAULT_FLAGS(5'b01111),
        .LOCK_CYCLES  (16)
`ifdef MENU_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(24'd100)
`endif
    ) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .Menu_Sw    (Menu_Sw),
        .BTN_UP     (BTN_UP),
        .BTN_DOWN   (BTN_DOWN),
        .BTN_SEL    (BTN_SEL),
        .Axis_On    (Axis_On),
        .Grid_On    (Grid_On),
        .Tick_On    (Tick_On),
        .Wave_On    (Wave_On),
        .Imba_On    (Imba_On),
        .Menu_Active(Menu_Active),
        .Cursor     (Cursor),
        .Cursor_Y   (Cursor_Y)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    typedef struct {
        logic       sw, up, down, sel;
        logic [2:0] cur;
        logic [11:0] y;
        logic [4:0] flags;
        logic       act;
    } vec_t;

    function automatic vec_t mk(input logic sw, up, down, sel, input logic [2:0] cur,
                                input logic [11:0] y, input logic [4:0] flags, input logic act);
        vec_t v;
        v.sw = sw; v.up = up; v.down = down; v.sel = sel;
        v.cur = cur; v.y = y; v.flags = flags; v.act = act;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        // Navigation table: one entry per clock edge.
        //                  sw up dn sel cur  y    flags    act
        vecs.push_back(mk(1, 0, 1, 0, 0, 688, 5'h0F, 1)); // open, DOWN held through reset
        vecs.push_back(mk(1, 0, 1, 0, 0, 688, 5'h0F, 1)); // held button: no press
        vecs.push_back(mk(1, 0, 0, 0, 0, 688, 5'h0F, 1));
        vecs.push_back(mk(1, 0, 1, 0, 1, 688, 5'h0F, 1));
        vecs.push_back(mk(1, 0, 0, 0, 1, 712, 5'h0F, 1));
        vecs.push_back(mk(1, 0, 1, 0, 2, 712, 5'h0F, 1));
        vecs.push_back(mk(1, 0, 0, 0, 2, 736, 5'h0F, 1));
        vecs.push_back(mk(1, 0, 1, 0, 3, 736, 5'h0F, 1));
        vecs.push_back(mk(1, 0, 0, 0, 3, 760, 5'h0F, 1));
        vecs.push_back(mk(1, 0, 1, 0, 4, 760, 5'h0F, 1));
        vecs.push_back(mk(1, 0, 0, 0, 4, 784, 5'h0F, 1));
        vecs.push_back(mk(1, 0, 1, 0, 0, 784, 5'h0F, 1)); // DOWN wraps 4 -> 0
        vecs.push_back(mk(1, 0, 0, 0, 0, 688, 5'h0F, 1));
        vecs.push_back(mk(1, 1, 0, 0, 4, 688, 5'h0F, 1)); // UP wraps 0 -> 4
        vecs.push_back(mk(1, 0, 0, 0, 4, 784, 5'h0F, 1));
        vecs.push_back(mk(1, 1, 1, 0, 4, 784, 5'h0F, 1)); // UP+DOWN: no-op
        vecs.push_back(mk(1, 0, 0, 0, 4, 784, 5'h0F, 1));
        vecs.push_back(mk(1, 1, 0, 0, 3, 784, 5'h0F, 1));
        vecs.push_back(mk(1, 0, 0, 0, 3, 760, 5'h0F, 1));
        vecs.push_back(mk(1, 1, 0, 0, 2, 760, 5'h0F, 1));
        vecs.push_back(mk(1, 0, 0, 0, 2, 736, 5'h0F, 1));
        vecs.push_back(mk(1, 0, 1, 1, 2, 736, 5'h0B, 1)); // SEL+DOWN: Tick toggles, cursor stays
        vecs.push_back(mk(1, 0, 0, 0, 2, 736, 5'h0B, 1));

        // Reset with DOWN held.
        RESET = 1'b1; Menu_Sw = 1'b0; BTN_UP = 1'b0; BTN_DOWN = 1'b1; BTN_SEL = 1'b0;
        repeat (3) tick();
        check("reset flags",    32'(flags_o),     32'h0F);
        check("reset cursor",   32'(Cursor),      32'd0);
        check("reset cursor_y", 32'(Cursor_Y),    32'd688);
        check("reset active",   32'(Menu_Active), 32'd0);
        RESET = 1'b0;

        foreach (vecs[i]) begin
            Menu_Sw = vecs[i].sw; BTN_UP = vecs[i].up; BTN_DOWN = vecs[i].down; BTN_SEL = vecs[i].sel;
            tick();
            check($sformatf("vec%0d cursor", i),   32'(Cursor),      32'(vecs[i].cur));
            check($sformatf("vec%0d cursor_y", i), 32'(Cursor_Y),    32'(vecs[i].y));
            check($sformatf("vec%0d flags", i),    32'(flags_o),     32'(vecs[i].flags));
            check($sformatf("vec%0d active", i),   32'(Menu_Active), 32'(vecs[i].act));
        end

        // Let the lockout expire, then move to row 4 (2 -> 1 -> 0 -> 4).
        BTN_DOWN = 1'b0; BTN_SEL = 1'b0; BTN_UP = 1'b0;
        repeat (20) tick();
        for (int k = 0; k < 3; k++) begin
            BTN_UP = 1'b1; tick();
            BTN_UP = 1'b0; tick();
        end
        check("row4 cursor",   32'(Cursor),   32'd4);
        check("row4 cursor_y", 32'(Cursor_Y), 32'd784);

        // Lockout: SEL at E0, lockout edges E1..E16, first NAV edge E17.
        BTN_SEL = 1'b1; tick();                        // E0
        check("sel imba set", 32'(flags_o), 32'h1B);
        BTN_SEL = 1'b0; repeat (7) tick();             // E1..E7
        BTN_SEL = 1'b1; tick();                        // E8: inside lockout
        check("sel in lockout ignored", 32'(Imba_On), 32'd1);
        BTN_SEL = 1'b0; repeat (7) tick();             // E9..E15
        BTN_SEL = 1'b1; tick();                        // E16: exit cycle
        check("sel on exit cycle ignored", 32'(Imba_On), 32'd1);
        check("lockout active", 32'(Menu_Active), 32'd1);
        BTN_SEL = 1'b0; tick();                        // E17
        BTN_SEL = 1'b1; tick();                        // E18: accepted
        check("sel after lockout", 32'(flags_o), 32'h0B);
        BTN_SEL = 1'b0; repeat (16) tick();            // E19..E34 lockout
        BTN_DOWN = 1'b1; tick();                       // E35: first NAV edge
        check("press on first nav cycle", 32'(Cursor), 32'd0);
        BTN_DOWN = 1'b0; tick();

        // Close during lockout, presses ignored while closed, reopen.
        BTN_DOWN = 1'b1; tick(); BTN_DOWN = 1'b0; tick();
        check("pre-close cursor", 32'(Cursor), 32'd1);
        BTN_SEL = 1'b1; tick();
        check("grid toggle", 32'(flags_o), 32'h09);
        BTN_SEL = 1'b0; tick();
        Menu_Sw = 1'b0; tick();
        check("close active", 32'(Menu_Active), 32'd0);
        check("close cursor", 32'(Cursor),      32'd0);
        check("close flags",  32'(flags_o),     32'h09);
        tick();
        check("close cursor_y", 32'(Cursor_Y), 32'd688);
        BTN_DOWN = 1'b1; tick();
        check("closed press ignored", 32'(Cursor), 32'd0);
        check("closed stays inactive", 32'(Menu_Active), 32'd0);
        BTN_DOWN = 1'b0; tick();
        Menu_Sw = 1'b1; tick();
        check("reopen active", 32'(Menu_Active), 32'd1);
        BTN_DOWN = 1'b1; tick();
        check("reopen nav", 32'(Cursor), 32'd1);
        BTN_DOWN = 1'b0; tick();

        // Reset in the middle of a lockout.
        BTN_SEL = 1'b1; tick();
        check("pre-reset toggle", 32'(flags_o), 32'h0B);
        BTN_SEL = 1'b0; tick();
        RESET = 1'b1; tick();
        check("midlock reset flags",  32'(flags_o),     32'h0F);
        check("midlock reset active", 32'(Menu_Active), 32'd0);
        check("midlock reset cursor", 32'(Cursor),      32'd0);
        RESET = 1'b0; tick();
        check("post-reset open", 32'(Menu_Active), 32'd1);
        BTN_DOWN = 1'b1; tick();
        check("post-reset nav", 32'(Cursor), 32'd1);
        BTN_DOWN = 1'b0; tick();

`ifdef MENU_TIMEOUT_EN
        // Idle auto-close after 100 NAV cycles without a press.
        Menu_Sw = 1'b0; tick();
        Menu_Sw = 1'b1; tick();                        // enter NAV, idle counter 0
        repeat (99) tick();
        check("timeout not yet", 32'(Menu_Active), 32'd1);
        tick();
        check("timeout active", 32'(Menu_Active), 32'd0);
        check("timeout cursor", 32'(Cursor),      32'd0);
        tick();
        check("timeout holds", 32'(Menu_Active), 32'd0);
        Menu_Sw = 1'b0; tick();
        Menu_Sw = 1'b1; tick();
        check("timeout reopen", 32'(Menu_Active), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
